uart_tx_serializer: RTL

Transmit engine for the CoreUART datapath. It drains bytes from the 128-entry TX FIFO through that FIFO's active-low read strobe and serialises each byte onto `txd`. Frame: start bit, 7 or 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from the ×OVERSAMPLE baud tick of the shared baud generator. The whole block runs on the system clock.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_serializer_if.sv | 20 ++
 rtl/uart_tx_serializer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the CoreUART datapath: transmit state encoding and
// the timing constants the TX engine relies on.
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;
  // Clocks from the read strobe being sampled by the FIFO to its output being valid.
  localparam int UART_FIFO_RD_LATENCY    = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_WAIT1,
    TX_WAIT2,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// TX FIFO read port as seen by the transmit engine (master) and the FIFO (slave).
interface uart_tx_serializer_if;

  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_n;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_n
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_n
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pulls one byte per frame from the TX FIFO and shifts it
// out as start / 7-8 data bits LSB first / optional parity / 1-2 stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 aresetn,
  input  logic                 baud_tick,
  input  logic                 bit8,
  input  logic                 parity_en,
  input  logic                 odd_n_even,
  uart_tx_serializer_if.master fifo,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                TICK_W          = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST       = TICK_W'(OVERSAMPLE - 1);
  localparam logic              STOP_LAST       = (STOP_BITS > 1);
  localparam bit                LOAD_FROM_WAIT1 = (UART_FIFO_RD_LATENCY < 2);

  tx_state_t         state_q,       state_d;
  logic [TICK_W-1:0] tick_cnt_q,    tick_cnt_d;
  logic [2:0]        bit_cnt_q,     bit_cnt_d;
  logic              stop_cnt_q,    stop_cnt_d;
  logic              bit8_q,        bit8_d;
  logic              parity_en_q,   parity_en_d;
  logic              parity_q,      parity_d;
  logic [7:0]        shreg_q,       shreg_d;
  logic              txd_q,         txd_d;
  logic              tx_busy_q,     tx_busy_d;
  logic              tx_done_q,     tx_done_d;
  logic              fifo_read_n_q, fifo_read_n_d;

  logic in_frame;
  logic bit_end;
  logic load;

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    bit8_d        = bit8_q;
    parity_en_d   = parity_en_q;
    parity_d      = parity_q;
    shreg_d       = shreg_q;
    tx_done_d     = 1'b0;
    fifo_read_n_d = 1'b1;
    load          = 1'b0;

    // Baud ticks only advance the bit timer while a frame is on the line.
    in_frame = state_q inside {TX_START, TX_DATA, TX_PARITY, TX_STOP};
    bit_end  = in_frame && baud_tick && (tick_cnt_q == TICK_LAST);
    if (in_frame && baud_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      TX_IDLE: begin
        if (!fifo.fifo_empty) begin
          state_d       = TX_FETCH;
          fifo_read_n_d = 1'b0;
        end
      end
      TX_FETCH: state_d = TX_WAIT1;
      TX_WAIT1: begin
        if (LOAD_FROM_WAIT1) load = 1'b1;
        else                 state_d = TX_WAIT2;
      end
      TX_WAIT2: load = 1'b1;
      TX_START: begin
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          // Last data bit index is 7 for 8-bit frames, 6 for 7-bit frames.
          if (bit_cnt_q == {2'b11, bit8_q}) begin
            bit_cnt_d = '0;
            state_d   = parity_en_q ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Byte and frame format are frozen here so config changes cannot tear a frame.
    if (load) begin
      state_d     = TX_START;
      shreg_d     = fifo.fifo_data;
      tick_cnt_d  = '0;
      bit_cnt_d   = '0;
      stop_cnt_d  = 1'b0;
      bit8_d      = bit8;
      parity_en_d = parity_en;
      parity_d    = (^(fifo.fifo_data & {bit8, 7'h7f})) ^ odd_n_even;
    end

    case (state_q)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = shreg_q[0];
      TX_PARITY: txd_d = parity_q;
      default:   txd_d = 1'b1;
    endcase

    tx_busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= TX_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      bit8_q        <= 1'b1;
      parity_en_q   <= 1'b0;
      txd_q         <= 1'b1;
      tx_busy_q     <= 1'b0;
      tx_done_q     <= 1'b0;
      fifo_read_n_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      bit8_q        <= bit8_d;
      parity_en_q   <= parity_en_d;
      txd_q         <= txd_d;
      tx_busy_q     <= tx_busy_d;
      tx_done_q     <= tx_done_d;
      fifo_read_n_q <= fifo_read_n_d;
    end
  end

  always_ff @(posedge clock) begin
    shreg_q  <= shreg_d;
    parity_q <= parity_d;
  end

  assign txd              = txd_q;
  assign tx_busy          = tx_busy_q;
  assign tx_done          = tx_done_q;
  assign fifo.fifo_read_n = fifo_read_n_q;

endmodule
